// File: rtl/fe_capture_sequencer_pkg.sv
// Shared state encodings and helpers for the front-end capture sequencer.
// The status register decodes O_state with these same encodings.
package fe_capture_sequencer_pkg;

    typedef enum logic [2:0] {
        FE_SEQ_S_IDLE    = 3'd0,
        FE_SEQ_S_ARMED   = 3'd1,
        FE_SEQ_S_DELAY   = 3'd2,
        FE_SEQ_S_CAPTURE = 3'd3,
        FE_SEQ_S_DONE    = 3'd4
    } fe_seq_state_e;

    localparam int TRIG_CNT_W = 4;

    function automatic logic [TRIG_CNT_W-1:0] sat_inc(input logic [TRIG_CNT_W-1:0] v);
        return (&v) ? v : v + TRIG_CNT_W'(1);
    endfunction

endpackage

// File: rtl/fe_seq_downcounter.sv
// Loadable down-counter that stops at zero; load takes priority over decrement.
module fe_seq_downcounter #(
    parameter int WIDTH = 20
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] value_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = value_i;
        else if (dec_i && cnt_q != '0)
            cnt_d = cnt_q - WIDTH'(1);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fe_capture_sequencer.sv
// Arms on I_arm rising edge, waits for a hw/sw trigger, applies a delay, then
// opens capture windows until the programmed trigger count is reached.
module fe_capture_sequencer
    import fe_capture_sequencer_pkg::*;
#(
    parameter int pDELAY_WIDTH  = 20,
    parameter int pWINDOW_WIDTH = 20
) (
    input  logic                     fe_clk,
    input  logic                     reset_i,
    input  logic                     I_arm,
    input  logic                     I_trigger,
    input  logic                     I_sw_trigger,
    input  logic [pDELAY_WIDTH-1:0]  I_trigger_delay,
    input  logic [pWINDOW_WIDTH-1:0] I_capture_window,
    input  logic [3:0]               I_num_triggers,
    input  logic                     I_capturing,
    output logic                     O_capture_enable,
    output logic                     O_armed,
    output logic                     O_done,
    output logic [3:0]               O_trigger_count,
    output logic                     O_missed_trigger,
    output logic [2:0]               O_state
);

    fe_seq_state_e state_q, state_d;
    logic arm_r_q, trig_r_q;
    logic [pDELAY_WIDTH-1:0]  dly_lat_q, dly_lat_d;
    logic [pWINDOW_WIDTH-1:0] win_lat_q, win_lat_d;
    logic [3:0] num_lat_q, num_lat_d;
    logic [3:0] count_q, count_d;
    logic       missed_q, missed_d;

    logic dly_load, dly_dec, dly_zero;
    logic win_load, win_dec, win_zero;
    logic [pDELAY_WIDTH-1:0]  dly_val;
    logic [pWINDOW_WIDTH-1:0] win_val;

    logic trig, arm_rise, win_inf;
    logic [3:0] num_eff;

    assign trig     = (I_trigger & ~trig_r_q) | I_sw_trigger;
    assign arm_rise = I_arm & ~arm_r_q;
    assign win_inf  = (win_lat_q == '0);
    assign num_eff  = (num_lat_q == 4'd0) ? 4'd1 : num_lat_q;
    assign dly_val  = (dly_lat_q == '0) ? '0 : dly_lat_q - pDELAY_WIDTH'(1);
    assign win_val  = win_inf ? '0 : win_lat_q - pWINDOW_WIDTH'(1);

    always_comb begin
        state_d   = state_q;
        dly_lat_d = dly_lat_q;
        win_lat_d = win_lat_q;
        num_lat_d = num_lat_q;
        count_d   = count_q;
        missed_d  = missed_q;
        dly_load  = 1'b0;
        dly_dec   = 1'b0;
        win_load  = 1'b0;
        win_dec   = 1'b0;

        // Configuration tracks the inputs while idle and freezes once armed.
        if (state_q == FE_SEQ_S_IDLE) begin
            dly_lat_d = I_trigger_delay;
            win_lat_d = I_capture_window;
            num_lat_d = I_num_triggers;
            count_d   = '0;
            missed_d  = 1'b0;
        end

        if (!I_arm) begin
            state_d = FE_SEQ_S_IDLE;
        end else begin
            case (state_q)
                FE_SEQ_S_IDLE: begin
                    if (arm_rise)
                        state_d = FE_SEQ_S_ARMED;
                end
                FE_SEQ_S_ARMED: begin
                    if (trig) begin
                        count_d = sat_inc(count_q);
                        if (dly_lat_q == '0) begin
                            state_d  = FE_SEQ_S_CAPTURE;
                            win_load = 1'b1;
                        end else begin
                            state_d  = FE_SEQ_S_DELAY;
                            dly_load = 1'b1;
                        end
                    end
                end
                FE_SEQ_S_DELAY: begin
                    if (trig)
                        missed_d = 1'b1;
                    if (dly_zero) begin
                        state_d  = FE_SEQ_S_CAPTURE;
                        win_load = 1'b1;
                    end else begin
                        dly_dec = 1'b1;
                    end
                end
                FE_SEQ_S_CAPTURE: begin
                    if (trig)
                        missed_d = 1'b1;
                    // Engine back-pressure ends the arm sequence outright.
                    if (!I_capturing)
                        state_d = FE_SEQ_S_DONE;
                    else if (!win_inf && win_zero)
                        state_d = (count_q < num_eff) ? FE_SEQ_S_ARMED : FE_SEQ_S_DONE;
                    else if (!win_inf)
                        win_dec = 1'b1;
                end
                FE_SEQ_S_DONE: ;
                default: state_d = FE_SEQ_S_IDLE;
            endcase
        end
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            state_q   <= FE_SEQ_S_IDLE;
            arm_r_q   <= 1'b0;
            trig_r_q  <= 1'b0;
            dly_lat_q <= '0;
            win_lat_q <= '0;
            num_lat_q <= '0;
            count_q   <= '0;
            missed_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            arm_r_q   <= I_arm;
            trig_r_q  <= I_trigger;
            dly_lat_q <= dly_lat_d;
            win_lat_q <= win_lat_d;
            num_lat_q <= num_lat_d;
            count_q   <= count_d;
            missed_q  <= missed_d;
        end
    end

    fe_seq_downcounter #(.WIDTH(pDELAY_WIDTH)) u_dly_cnt (
        .clk_i   (fe_clk),
        .reset_i (reset_i),
        .load_i  (dly_load),
        .value_i (dly_val),
        .dec_i   (dly_dec),
        .zero_o  (dly_zero)
    );

    fe_seq_downcounter #(.WIDTH(pWINDOW_WIDTH)) u_win_cnt (
        .clk_i   (fe_clk),
        .reset_i (reset_i),
        .load_i  (win_load),
        .value_i (win_val),
        .dec_i   (win_dec),
        .zero_o  (win_zero)
    );

    assign O_capture_enable = (state_q == FE_SEQ_S_CAPTURE);
    assign O_armed          = (state_q == FE_SEQ_S_ARMED) || (state_q == FE_SEQ_S_DELAY) ||
                              (state_q == FE_SEQ_S_CAPTURE);
    assign O_done           = (state_q == FE_SEQ_S_DONE);
    assign O_trigger_count  = count_q;
    assign O_missed_trigger = missed_q;
    assign O_state          = state_q;

endmodule

// File: tb/tb_fe_capture_sequencer.sv
// Directed bench for fe_capture_sequencer: arming, delay/window timing,
// multi-trigger, missed triggers, back-pressure, disarm and reset.
module tb_fe_capture_sequencer;

    logic        fe_clk = 1'b0;
    logic        reset_i;
    logic        I_arm, I_trigger, I_sw_trigger, I_capturing;
    logic [19:0] I_trigger_delay, I_capture_window;
    logic [3:0]  I_num_triggers;
    logic        O_capture_enable, O_armed, O_done, O_missed_trigger;
    logic [3:0]  O_trigger_count;
    logic [2:0]  O_state;

    int checks = 0;
    int errors = 0;

    always #5 fe_clk = ~fe_clk;

    fe_capture_sequencer dut (
        .fe_clk           (fe_clk),
        .reset_i          (reset_i),
        .I_arm            (I_arm),
        .I_trigger        (I_trigger),
        .I_sw_trigger     (I_sw_trigger),
        .I_trigger_delay  (I_trigger_delay),
        .I_capture_window (I_capture_window),
        .I_num_triggers   (I_num_triggers),
        .I_capturing      (I_capturing),
        .O_capture_enable (O_capture_enable),
        .O_armed          (O_armed),
        .O_done           (O_done),
        .O_trigger_count  (O_trigger_count),
        .O_missed_trigger (O_missed_trigger),
        .O_state          (O_state)
    );

    task automatic tick();
        @(posedge fe_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg(input int d, input int w, input int n);
        I_trigger_delay  = 20'(d);
        I_capture_window = 20'(w);
        I_num_triggers   = 4'(n);
    endtask

    task automatic disarm();
        I_arm = 1'b0;
        tick();
        check("disarm_state", 32'(O_state), 0);
        check("disarm_en", 32'(O_capture_enable), 0);
    endtask

    initial begin
        reset_i = 1'b1; I_arm = 1'b0; I_trigger = 1'b0; I_sw_trigger = 1'b0;
        I_capturing = 1'b1;
        cfg(0, 0, 0);
        tick(); tick();
        reset_i = 1'b0;
        check("rst_state", 32'(O_state), 0);
        check("rst_en", 32'(O_capture_enable), 0);
        check("rst_armed", 32'(O_armed), 0);
        check("rst_done", 32'(O_done), 0);
        check("rst_count", 32'(O_trigger_count), 0);
        check("rst_missed", 32'(O_missed_trigger), 0);

        // Test 1: D=0 W=4 N=1, hw trigger edge
        cfg(0, 4, 1);
        I_arm = 1'b1;
        tick();
        check("t1_armed_state", 32'(O_state), 1);
        check("t1_armed", 32'(O_armed), 1);
        cfg(7, 9, 5);  // ignored once armed
        I_trigger = 1'b1;
        tick();
        check("t1_count", 32'(O_trigger_count), 1);
        for (int i = 0; i < 4; i++) begin
            check("t1_en_high", 32'(O_capture_enable), 1);
            tick();
        end
        I_trigger = 1'b0;
        check("t1_en_low", 32'(O_capture_enable), 0);
        check("t1_done", 32'(O_done), 1);
        check("t1_state", 32'(O_state), 4);
        tick(); tick();
        check("t1_done_hold", 32'(O_state), 4);
        disarm();

        // Test 2: D=10 W=3 N=1, sw pulse; arm+trig together drops the trigger
        cfg(10, 3, 1);
        I_arm = 1'b1; I_sw_trigger = 1'b1;
        tick();
        I_sw_trigger = 1'b0;
        check("t2_arm_only_state", 32'(O_state), 1);
        check("t2_arm_only_count", 32'(O_trigger_count), 0);
        tick();
        I_sw_trigger = 1'b1;
        tick();
        I_sw_trigger = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("t2_delay_en", 32'(O_capture_enable), 0);
            check("t2_delay_state", 32'(O_state), 2);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            check("t2_win_en", 32'(O_capture_enable), 1);
            tick();
        end
        check("t2_after_en", 32'(O_capture_enable), 0);
        check("t2_done", 32'(O_done), 1);
        disarm();

        // Test 3: N=3 W=2 D=0, triggers 5 cycles apart
        cfg(0, 2, 3);
        I_arm = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            I_trigger = 1'b1;
            tick();
            I_trigger = 1'b0;
            check("t3_en1", 32'(O_capture_enable), 1);
            check("t3_count", 32'(O_trigger_count), 32'(k + 1));
            tick();
            check("t3_en2", 32'(O_capture_enable), 1);
            tick();
            check("t3_gap_en", 32'(O_capture_enable), 0);
            check("t3_gap_state", 32'(O_state), (k < 2) ? 1 : 4);
            tick(); tick();
        end
        I_trigger = 1'b1;
        tick();
        I_trigger = 1'b0;
        tick();
        check("t3_4th_count", 32'(O_trigger_count), 3);
        check("t3_4th_done", 32'(O_done), 1);
        check("t3_4th_missed", 32'(O_missed_trigger), 0);
        disarm();

        // Test 4: W=0 open window ended by I_capturing at cycle 20
        cfg(0, 0, 1);
        I_arm = 1'b1;
        tick();
        I_sw_trigger = 1'b1;
        tick();
        I_sw_trigger = 1'b0;
        for (int i = 1; i < 20; i++) begin
            check("t4_open_en", 32'(O_capture_enable), 1);
            tick();
        end
        check("t4_c20_en", 32'(O_capture_enable), 1);
        I_capturing = 1'b0;
        tick();
        I_capturing = 1'b1;
        check("t4_stop_en", 32'(O_capture_enable), 0);
        check("t4_stop_state", 32'(O_state), 4);
        disarm();

        // Test 5: D=100, extra trigger during DELAY is missed, timing unchanged
        cfg(100, 3, 1);
        I_arm = 1'b1;
        tick();
        I_sw_trigger = 1'b1;
        tick();                       // now cycle T+1
        I_sw_trigger = 1'b0;
        tick(); tick(); tick(); tick(); // T+5
        I_sw_trigger = 1'b1;
        tick();                       // T+6
        I_sw_trigger = 1'b0;
        check("t5_missed", 32'(O_missed_trigger), 1);
        check("t5_count", 32'(O_trigger_count), 1);
        check("t5_state", 32'(O_state), 2);
        for (int i = 0; i < 94; i++) tick(); // T+100
        check("t5_pre_en", 32'(O_capture_enable), 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            check("t5_win_en", 32'(O_capture_enable), 1);
            tick();
        end
        check("t5_after_en", 32'(O_capture_enable), 0);
        check("t5_done", 32'(O_done), 1);
        check("t5_missed_sticky", 32'(O_missed_trigger), 1);
        disarm();

        // Test 6: disarm mid-CAPTURE, re-arm clears status, reset mid-DELAY
        cfg(0, 8, 1);
        I_arm = 1'b1;
        tick();
        I_trigger = 1'b1;
        tick();
        I_trigger = 1'b0;
        I_sw_trigger = 1'b1;
        tick();
        I_sw_trigger = 1'b0;
        check("t6_missed_cap", 32'(O_missed_trigger), 1);
        check("t6_cap_en", 32'(O_capture_enable), 1);
        disarm();
        check("t6_disarm_armed", 32'(O_armed), 0);
        I_arm = 1'b1;
        tick();
        check("t6_rearm_state", 32'(O_state), 1);
        check("t6_rearm_count", 32'(O_trigger_count), 0);
        check("t6_rearm_missed", 32'(O_missed_trigger), 0);
        disarm();
        cfg(50, 4, 1);
        I_arm = 1'b1;
        tick();
        I_sw_trigger = 1'b1;
        tick();
        I_sw_trigger = 1'b0;
        tick(); tick();
        check("t6_in_delay", 32'(O_state), 2);
        reset_i = 1'b1; I_arm = 1'b0;
        tick();
        reset_i = 1'b0;
        check("t6_rst_state", 32'(O_state), 0);
        check("t6_rst_en", 32'(O_capture_enable), 0);
        check("t6_rst_armed", 32'(O_armed), 0);
        check("t6_rst_done", 32'(O_done), 0);
        check("t6_rst_count", 32'(O_trigger_count), 0);
        check("t6_rst_missed", 32'(O_missed_trigger), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
